// File: rtl/acs_sched_213.sv
// ---------------------------------------------------------------------------
// acs_sched_213 -- add-compare-select scheduler for a (2,1,3) Viterbi decoder
// (generators g0=111, g1=101, 4 trellis states) that time-shares one external
// ACS unit across all four next-states.
//
// Each accepted hard-decision symbol takes 6 cycles:
// IDLE (accept) -> RUN x4 (one next-state per cycle) -> DONE (results valid).
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   sym_valid    : received symbol present
//   sym_in       : received code bits {c0,c1}
//   sym_ready    : block accepts a symbol this cycle (IDLE only)
//   init         : synchronous metric-bank reinitialise, also aborts a run
//   acs_ppm_ina  : upper predecessor metric to ACS unit
//   acs_ppm_inb  : lower predecessor metric to ACS unit
//   HD_ina       : upper (saturated) branch metric to ACS unit
//   HD_inb       : lower (saturated) branch metric to ACS unit
//   acs_ppm_out  : selected metric from ACS unit
//   acs_Bx_out   : ACS decision, 0 = upper, 1 = lower
//   surv         : survivor bits, bit n belongs to next-state n
//   surv_valid   : one-cycle strobe qualifying surv and best_state
//   best_state   : index of minimum new metric (lowest index on ties)
//
// Build option
//   ACS_SCHED_213_NORM_EN : when defined, the minimum new metric is subtracted
//                           from every non-saturated metric as it is written
//                           back to the bank.
// ---------------------------------------------------------------------------
module acs_sched_213 #(
    parameter int W  = 4,
    parameter int NS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sym_valid,
    input  logic [1:0]   sym_in,
    output logic         sym_ready,
    input  logic         init,
    output logic [W-1:0] acs_ppm_ina,
    output logic [W-1:0] acs_ppm_inb,
    output logic [W-1:0] HD_ina,
    output logic [W-1:0] HD_inb,
    input  logic [W-1:0] acs_ppm_out,
    input  logic         acs_Bx_out,
    output logic [3:0]   surv,
    output logic         surv_valid,
    output logic [1:0]   best_state
);

    localparam logic [W-1:0] MAX_METRIC = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   sym_q, sym_d;
    logic [W-1:0] bank_q   [NS];
    logic [W-1:0] bank_d   [NS];
    logic [W-1:0] shadow_q [NS];
    logic [W-1:0] shadow_d [NS];
    logic [3:0]   surv_q, surv_d;
    logic         surv_valid_q, surv_valid_d;
    logic [1:0]   best_q, best_d;

    logic [W-1:0] bank_load  [NS];
    logic [W-1:0] new_metric [NS];
    logic [W-1:0] best_val;
    logic [1:0]   new_best;
    logic         nu, na;

    // Branch code leaving predecessor {a,b} on input bit u: {c0,c1}.
    function automatic logic [1:0] branch_code(input logic u, input logic a, input logic b);
        return {u ^ a ^ b, u ^ b};
    endfunction

    // Hamming distance clipped so that metric + branch metric never exceeds
    // the saturated value; a saturated predecessor therefore gets 0.
    function automatic logic [W-1:0] sat_bm(input logic [1:0] sym, input logic [1:0] code,
                                            input logic [W-1:0] m);
        logic [1:0]   diff;
        logic [W-1:0] h;
        logic [W-1:0] room;
        diff = sym ^ code;
        h    = W'({1'b0, diff[1]} + {1'b0, diff[0]});
        room = MAX_METRIC - m;
        return (h < room) ? h : room;
    endfunction

    // Next-state under evaluation is cnt = {u,a}; predecessors are {a,0}/{a,1}.
    assign nu = cnt_q[1];
    assign na = cnt_q[0];

    always_comb begin
        acs_ppm_ina = '0;
        acs_ppm_inb = '0;
        HD_ina      = '0;
        HD_inb      = '0;
        if (state_q == RUN) begin
            acs_ppm_ina = bank_q[{na, 1'b0}];
            acs_ppm_inb = bank_q[{na, 1'b1}];
            HD_ina      = sat_bm(sym_q, branch_code(nu, na, 1'b0), bank_q[{na, 1'b0}]);
            HD_inb      = sat_bm(sym_q, branch_code(nu, na, 1'b1), bank_q[{na, 1'b1}]);
        end
    end

    // The last new metric arrives from the ACS unit in the same cycle the
    // best state must be registered, so it bypasses the shadow store.
    for (genvar gi = 0; gi < NS; gi++) begin : g_metric
        assign new_metric[gi] = (gi == NS - 1) ? acs_ppm_out : shadow_q[gi];
    end

    always_comb begin
        new_best = 2'd0;
        best_val = new_metric[0];
        for (int i = 1; i < NS; i++) begin
            if (new_metric[i] < best_val) begin
                best_val = new_metric[i];
                new_best = 2'(i);
            end
        end
    end

`ifdef ACS_SCHED_213_NORM_EN
    logic [W-1:0] shadow_min;

    always_comb begin
        shadow_min = shadow_q[0];
        for (int i = 1; i < NS; i++) begin
            if (shadow_q[i] < shadow_min) begin
                shadow_min = shadow_q[i];
            end
        end
    end

    for (genvar gi = 0; gi < NS; gi++) begin : g_norm
        assign bank_load[gi] = (shadow_q[gi] == MAX_METRIC) ? MAX_METRIC
                                                            : shadow_q[gi] - shadow_min;
    end
`else
    for (genvar gi = 0; gi < NS; gi++) begin : g_norm
        assign bank_load[gi] = shadow_q[gi];
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        bank_d       = bank_q;
        shadow_d     = shadow_q;
        surv_d       = surv_q;
        surv_valid_d = 1'b0;
        best_d       = best_q;
        case (state_q)
            IDLE: begin
                // init wins over a symbol offered in the same cycle
                if (init) begin
                    for (int i = 0; i < NS; i++) bank_d[i] = (i == 0) ? '0 : MAX_METRIC;
                end else if (sym_valid) begin
                    state_d = RUN;
                    sym_d   = sym_in;
                    cnt_d   = 2'd0;
                end
            end
            RUN: begin
                if (init) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                    for (int i = 0; i < NS; i++) bank_d[i] = (i == 0) ? '0 : MAX_METRIC;
                end else begin
                    shadow_d[cnt_q] = acs_ppm_out;
                    surv_d[cnt_q]   = acs_Bx_out;
                    cnt_d           = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d      = DONE;
                        surv_valid_d = 1'b1;
                        best_d       = new_best;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (init) begin
                    for (int i = 0; i < NS; i++) bank_d[i] = (i == 0) ? '0 : MAX_METRIC;
                end else begin
                    bank_d = bank_load;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            sym_q        <= 2'd0;
            surv_q       <= 4'd0;
            surv_valid_q <= 1'b0;
            best_q       <= 2'd0;
            for (int i = 0; i < NS; i++) begin
                bank_q[i]   <= (i == 0) ? '0 : MAX_METRIC;
                shadow_q[i] <= MAX_METRIC;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            surv_q       <= surv_d;
            surv_valid_q <= surv_valid_d;
            best_q       <= best_d;
            bank_q       <= bank_d;
            shadow_q     <= shadow_d;
        end
    end

    assign sym_ready  = (state_q == IDLE);
    assign surv       = surv_q;
    assign surv_valid = surv_valid_q;
    assign best_state = best_q;

endmodule

// File: doc/acs_sched_213.md
ACS_SCHED_213 -- requirements
Module: acs_sched_213

Interface
REQ-001 Parameter W, default 4: path-metric and branch-metric width; the all-ones value (15) is the saturated "unreachable" metric.
REQ-002 Parameter NS, default 4: trellis state count for the (2,1,3) code with generators g0=111, g1=101; fixed at 4.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sym_valid, input, 1: received hard-decision symbol is present.
REQ-006 Port sym_in, input, 2: received code bits {c0,c1}.
REQ-007 Port sym_ready, output, 1: block accepts a symbol this cycle.
REQ-008 Port init, input, 1: synchronous metric-bank reinitialise.
REQ-009 Port acs_ppm_ina / acs_ppm_inb, output, W each: upper/lower predecessor metrics to the shared ACS unit.
REQ-010 Port HD_ina / HD_inb, output, W each: upper/lower branch metrics to the shared ACS unit.
REQ-011 Port acs_ppm_out, input, W: selected metric returned by the ACS unit.
REQ-012 Port acs_Bx_out, input, 1: ACS decision; 0 = upper, 1 = lower.
REQ-013 Port surv, output, 4: survivor decision bits; bit n belongs to next-state n.
REQ-014 Port surv_valid, output, 1: one-cycle strobe qualifying surv and best_state.
REQ-015 Port best_state, output, 2: index of the minimum new metric; the lowest index wins ties.

Function
REQ-016 State encoding: s={u[t-1],u[t-2]}; next state ns={u,s[1]}; the branch code from p={a,b} on input u is c0=u^a^b, c1=u^b.
REQ-017 Predecessors of ns={u,a}: upper={a,0}, lower={a,1}.
REQ-018 Branch metric: Hamming distance between sym_in and the branch code, range 0..2.
REQ-019 FSM states: IDLE, RUN, DONE. sym_ready=1 only in IDLE.
REQ-020 IDLE->RUN on sym_valid&&sym_ready; sym_in is latched and the counter cnt is set to 0.
REQ-021 RUN: in each cycle the block drives the ACS ports combinationally for next-state cnt and captures acs_ppm_out into shadow[cnt] and acs_Bx_out into surv[cnt].
REQ-022 RUN: cnt increments 0..3; at cnt=3 the FSM moves to DONE.
REQ-023 surv_valid is registered and is high only during the DONE cycle; surv and best_state are stable while surv_valid=1.
REQ-024 DONE->IDLE on the next edge; on that edge the metric bank is loaded from shadow (post-processed per REQ-033).
REQ-025 Throughput: one symbol per 6 cycles; surv_valid rises 5 cycles after the accept edge.
REQ-026 Saturation: a predecessor metric of 15 is passed as-is.
REQ-027 Saturation: for a predecessor metric m<15 with branch metric h, HD is driven as min(h,15-m), so no sum exceeds 15.
REQ-028 Outside RUN, the ACS output ports are driven to 0.
REQ-029 init in IDLE or DONE: the bank is set to {0,15,15,15} on the next edge.
REQ-030 init in RUN: the symbol is aborted, the bank is reinitialised, the FSM returns to IDLE, and surv_valid is not asserted.
REQ-031 init has priority over sym_valid in the same cycle; the symbol is not accepted.

Reset
REQ-032 reset forces: FSM=IDLE, cnt=0, bank={0,15,15,15}, shadow=all 15, surv=0, surv_valid=0, best_state=0, sym_ready=1 in the following cycle. This applies mid-operation and takes priority over init.

Configuration
REQ-033 Macro ACS_SCHED_213_NORM_EN defined: at the DONE->IDLE edge, min(shadow) is subtracted from every shadow value below 15; values equal to 15 stay 15.
REQ-034 Macro ACS_SCHED_213_NORM_EN undefined: shadow values are written to the bank unmodified.

Verification
REQ-035 reset; sym 11 -> surv_valid 5 cycles after accept; surv=4'b0000, bank={2,15,0,15}, best_state=2.
REQ-036 Continue with sym 10 -> surv=4'b0000, bank={3,0,3,2}, best_state=1.
REQ-037 Continue with sym 01 -> surv=4'b0111, best_state=0; bank={0,1,0,2} with NORM_EN, {1,2,1,3} without.
REQ-038 Assert init during RUN cnt=2 -> no surv_valid; next sym 00 yields surv=0000 and bank={0,15,2,15}.
REQ-039 Hold sym_valid=1 continuously -> sym_ready pulses every 6th cycle and exactly one symbol is accepted per pulse.
REQ-040 Assert reset in DONE -> surv_valid=0 next cycle, bank={0,15,15,15}, FSM in IDLE.
